// File: rtl/spn_cu_pkg.sv
// spn_cu_pkg: shared SPN core types plus scheduler state, requester count and status lookup
package spn_cu_pkg;
   typedef enum logic [1:0] {no_op = 2'b00, encrypt = 2'b01, decrypt = 2'b10, undefined = 2'b11} opcode_t;
   typedef enum logic [1:0] {
      unsuccessful          = 2'b00,
      successful_encryption = 2'b01,
      successful_decryption = 2'b10,
      invalid_status        = 2'b11
   } valid_t;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} sched_state_t;
   localparam int N_REQ = 2;
   function automatic valid_t expected_valid(opcode_t op);
      return op == encrypt ? successful_encryption : op == decrypt ? successful_decryption : unsuccessful;
   endfunction
endpackage

// File: rtl/spn_cu_rr_arbiter.sv
// spn_cu_rr_arbiter: combinational 2-way round-robin arbiter
//   req        in   per-requester request
//   last_grant in   index of the most recent winner
//   grant      out  one-hot winner, 0 when nobody requests
module spn_cu_rr_arbiter
   import spn_cu_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic             last_grant,
   output logic [N_REQ-1:0] grant
);
   always_comb grant = &req ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/spn_cu_scheduler.sv
// spn_cu_scheduler: shares one SPN core between two requesters, one operation in flight
//   req_*   valid/ready request channel per requester (opcode, data, key)
//   resp_*  valid/ready response channel; resp_data/resp_ok shared, qualified by resp_valid
//   core_*  drive and capture the core's opcode/data/key and data_out/valid
module spn_cu_scheduler
   import spn_cu_pkg::*;
#(
   parameter int CORE_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  opcode_t [N_REQ-1:0]    req_opcode,
   input  logic [N_REQ-1:0][15:0] req_data,
   input  logic [N_REQ-1:0][31:0] req_key,
   output logic [N_REQ-1:0]       resp_valid,
   input  logic [N_REQ-1:0]       resp_ready,
   output logic [15:0]            resp_data,
   output logic                   resp_ok,
   output opcode_t                core_opcode,
   output logic [15:0]            core_data_in,
   output logic [31:0]            core_key,
   input  logic [15:0]            core_data_out,
   input  valid_t                 core_valid
);
   localparam int CW = $clog2(CORE_LATENCY + 1);
   sched_state_t    state, state_nxt;
   logic            owner, last_grant, g, accept, legal, done, resp_done;
   logic [CW-1:0]   cnt;
   logic [N_REQ-1:0] grant;
   opcode_t         sel_op;
   spn_cu_rr_arbiter u_arb (.req(req_valid), .last_grant(last_grant), .grant(grant));
   assign g         = grant[1];
   assign sel_op    = req_opcode[g];
   assign legal     = sel_op == encrypt || sel_op == decrypt;
   assign accept    = |req_ready;
   assign done      = state == BUSY && cnt == CW'(CORE_LATENCY);
   assign resp_done = state == RESP && resp_ready[owner];
   always_comb begin
      req_ready  = state == IDLE ? grant : '0;
      resp_valid = state == RESP ? (N_REQ'(1) << owner) : '0;
      state_nxt  = accept ? (legal ? BUSY : RESP) : done ? RESP : resp_done ? IDLE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         cnt          <= '0;
         resp_data    <= '0;
         resp_ok      <= 1'b0;
         core_opcode  <= no_op;
         core_data_in <= '0;
         core_key     <= '0;
      end else if (accept) begin
         owner      <= g;
         last_grant <= g;
         cnt        <= '0;
         if (legal) begin
            core_opcode  <= sel_op;
            core_data_in <= req_data[g];
            core_key     <= req_key[g];
         end else begin
            resp_data <= '0;
            resp_ok   <= 1'b0;
         end
      end else if (state == BUSY) begin
         cnt <= &cnt ? cnt : cnt + 1'b1;
         if (done) begin
            resp_data   <= core_data_out;
            resp_ok     <= core_valid == expected_valid(core_opcode);
            core_opcode <= no_op;
         end
      end
   end
endmodule
